// File: rtl/bf16_add_arb.sv
// Round-robin arbiter feeding one shared bf16 adder through a two-stage
// operand/result pipeline with a tagged valid/ready response channel.

module bf16_add (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    // Inputs with a zero exponent count as signed zero, tiny results flush
    // to signed zero, rounding is round-to-nearest-even, NaN out is 0x7FC0.
    logic              sa, sb, sx, sy;
    logic [7:0]        ea, eb, ex, ey, d;
    logic [6:0]        ma, mb, mx, my;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
    logic [18:0]       xs, ys, sum;
    logic [17:0]       norm;
    logic [4:0]        lz;
    logic [7:0]        rmant;
    logic              rnd;
    logic signed [9:0] er;

    assign {sa, ea, ma} = a;
    assign {sb, eb, mb} = b;
    assign a_nan  = (ea == 8'hFF) && (ma != 7'd0);
    assign b_nan  = (eb == 8'hFF) && (mb != 7'd0);
    assign a_inf  = (ea == 8'hFF) && (ma == 7'd0);
    assign b_inf  = (eb == 8'hFF) && (mb == 7'd0);
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign a_big  = {ea, ma} >= {eb, mb};
    assign {sx, ex, mx} = a_big ? a : b;
    assign {sy, ey, my} = a_big ? b : a;
    assign d   = ex - ey;

    // Ten extra low bits keep the sum exact for every shift below 10.
    assign xs  = {1'b0, 1'b1, mx, 10'd0};
    assign ys  = {1'b0, 1'b1, my, 10'd0} >> d;
    assign sum = (sx == sy) ? xs + ys : xs - ys;

    always_comb begin : lead_zero
        lz = 5'd0;
        for (int i = 0; i < 19; i++) begin
            if (sum[i]) lz = 5'(18 - i);
        end
    end

    assign norm  = 18'(sum << lz);
    assign rnd   = norm[10] & ((|norm[9:0]) | norm[11]);
    assign rmant = 8'(norm[17:11]) + 8'(rnd);
    assign er    = 10'(ex) + 10'd1 - 10'(lz) + 10'(rmant[7]);

    always_comb begin : result_sel
        y = {sx, er[7:0], (rmant[7] ? 7'd0 : rmant[6:0])};
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            y = 16'h7FC0;
        end else if (a_inf) begin
            y = a;
        end else if (b_inf) begin
            y = b;
        end else if (a_zero && b_zero) begin
            y = {sa & sb, 15'd0};
        end else if (a_zero) begin
            y = b;
        end else if (b_zero) begin
            y = a;
        end else if (d >= 8'd10) begin
            // Smaller operand is below a quarter ulp: the larger one wins.
            y = {sx, ex, mx};
        end else if (sum == 19'd0) begin
            y = 16'h0000;
        end else if (er >= 10'sd255) begin
            y = {sx, 8'hFF, 7'd0};
        end else if (er <= 10'sd0) begin
            y = {sx, 15'd0};
        end
    end
endmodule

module bf16_add_arb #(
    parameter  int unsigned N     = 4,
    parameter  int unsigned CNT_W = 16,
    localparam int unsigned ID_W  = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid_i,
    output logic [N-1:0]      req_ready_o,
    input  logic [16*N-1:0]   req_a_i,
    input  logic [16*N-1:0]   req_b_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [ID_W-1:0]   rsp_id_o,
    output logic [15:0]       rsp_data_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  done_cnt_o
);
    logic             s1_v, s2_v, s1_en, s2_en, any_v;
    logic [ID_W-1:0]  s1_id, s2_id, ptr, ptr_nxt, gnt_id, idx;
    logic [15:0]      s1_a, s1_b, s2_data, add_y, sel_a, sel_b;
    logic [N-1:0]     grant;
    logic [CNT_W-1:0] done_cnt;

    assign s2_en = ~s2_v | rsp_ready_i;
    assign s1_en = ~s1_v | s2_en;

    // First valid requester at or after ptr, wrapping modulo N.
    always_comb begin : rr_pick
        grant  = '0;
        gnt_id = '0;
        any_v  = 1'b0;
        idx    = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ID_W'((32'(ptr) + k) % N);
            if (!any_v && req_valid_i[idx]) begin
                any_v       = 1'b1;
                gnt_id      = idx;
                grant[idx]  = 1'b1;
                sel_a       = req_a_i[{idx, 4'b0000} +: 16];
                sel_b       = req_b_i[{idx, 4'b0000} +: 16];
            end
        end
    end

    assign ptr_nxt     = (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + ID_W'(1);
    assign req_ready_o = rst ? '0 : (grant & {N{s1_en}});

    bf16_add u_add (
        .a (s1_a),
        .b (s1_b),
        .y (add_y)
    );

    always_ff @(posedge clk) begin : pipe_regs
        if (rst) begin
            s1_v     <= 1'b0;
            s1_id    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_v     <= 1'b0;
            s2_id    <= '0;
            s2_data  <= '0;
            ptr      <= '0;
            done_cnt <= '0;
        end else begin
            if (s1_en) begin
                s1_v <= any_v;
                if (any_v) begin
                    s1_id <= gnt_id;
                    s1_a  <= sel_a;
                    s1_b  <= sel_b;
                    ptr   <= ptr_nxt;
                end
            end
            if (s2_en) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_id   <= s1_id;
                    s2_data <= add_y;
                end
            end
            if (s2_v && rsp_ready_i) begin
                done_cnt <= done_cnt + CNT_W'(1);
            end
        end
    end

    assign rsp_valid_o = s2_v;
    assign rsp_id_o    = s2_id;
    assign rsp_data_o  = s2_data;
    assign busy_o      = s1_v | s2_v;
    assign done_cnt_o  = done_cnt;
endmodule
